pipe_ctrl: RTL

Central pipeline stall/sequencing controller for the 5-stage core (PC, IF, ID, EX, MEM, WB).
- Merges ID-stage stall requests (load-use hazard) with an internal FSM that sequences a multi-cycle EX operation, such as an iterative divider.
- Produces the per-stage stall vector consumed by the pc_reg, if_id, id_ex, ex_mem and mem_wb pipeline registers.
- Gives the iterative EX unit its load/step/done timing.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_ctrl_if.sv | 46 ++++
 rtl/pipe_ctrl_perf_cnt.sv | 20 ++
 rtl/pipe_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/sequencing controller: stall vector
// layout, canonical stall patterns and FSM state encodings.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;
    localparam int PERF_W  = 32;

    localparam int STAGE_PC  = 0;
    localparam int STAGE_IF  = 1;
    localparam int STAGE_ID  = 2;
    localparam int STAGE_EX  = 3;
    localparam int STAGE_MEM = 4;
    localparam int STAGE_WB  = 5;

    typedef logic [STALL_W-1:0] stall_vec_t;

    // An ID hazard freezes PC/IF/ID; an EX op additionally freezes EX
    localparam stall_vec_t StallNone   = 6'b000000;
    localparam stall_vec_t StallFromId = 6'b000111;
    localparam stall_vec_t StallFromEx = 6'b001111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between pipe_ctrl and the pipeline / iterative EX unit.
// Perf counter signals exist only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 6
) ();

    logic             stallreq_id;
    logic             mc_start;
    logic             flush;
    stall_vec_t       stall;
    logic             mc_load;
    logic             mc_step;
    logic             mc_done;
    logic             mc_busy;
    logic [CNT_W-1:0] mc_cnt;
`ifdef PIPE_CTRL_PERF_EN
    logic              perf_clr;
    logic [PERF_W-1:0] stall_cycles;
    logic [PERF_W-1:0] mc_ops;

    modport master (
        input  stallreq_id, mc_start, flush, perf_clr,
        output stall, mc_load, mc_step, mc_done, mc_busy, mc_cnt,
               stall_cycles, mc_ops
    );

    modport slave (
        output stallreq_id, mc_start, flush, perf_clr,
        input  stall, mc_load, mc_step, mc_done, mc_busy, mc_cnt,
               stall_cycles, mc_ops
    );
`else
    modport master (
        input  stallreq_id, mc_start, flush,
        output stall, mc_load, mc_step, mc_done, mc_busy, mc_cnt
    );

    modport slave (
        output stallreq_id, mc_start, flush,
        input  stall, mc_load, mc_step, mc_done, mc_busy, mc_cnt
    );
`endif

endinterface

// File: rtl/pipe_ctrl_perf_cnt.sv
// Saturating event counter; clear wins over increment in the same cycle.
module pipe_perf_cnt
    import pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {PERF_W{1'b1}})) begin
            count <= count + PERF_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall merger and multi-cycle EX sequencer (IDLE -> RUN -> DONE).
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CYCLES = 32,
    parameter int CNT_W     = 6
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.master bus
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ex_stall;
    stall_vec_t       stall_vec;
    logic             done;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.mc_start) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == CNT_W'(MC_CYCLES - 1)) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // mc_start is still high here for the finishing op; never restart from DONE
                ST_DONE: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_stall = ((state_q == ST_IDLE) && bus.mc_start) || (state_q == ST_RUN);

    always_comb begin
        stall_vec = StallNone;
        if (!rst && !bus.flush) begin
            if (ex_stall) begin
                stall_vec = StallFromEx;
            end else if (bus.stallreq_id) begin
                stall_vec = StallFromId;
            end
        end
    end

    // Everything reads as zero while rst is held, even before the reset edge
    assign done        = !rst && !bus.flush && (state_q == ST_DONE);
    assign bus.stall   = stall_vec;
    assign bus.mc_load = !rst && !bus.flush && (state_q == ST_IDLE) && bus.mc_start;
    assign bus.mc_step = !rst && !bus.flush && (state_q == ST_RUN);
    assign bus.mc_done = done;
    assign bus.mc_busy = !rst && (state_q != ST_IDLE);
    assign bus.mc_cnt  = rst ? '0 : cnt_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] ops_cnt;

    pipe_perf_cnt u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.perf_clr),
        .inc   (stall_vec[STAGE_PC]),
        .count (stall_cnt)
    );

    pipe_perf_cnt u_ops_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.perf_clr),
        .inc   (done),
        .count (ops_cnt)
    );

    assign bus.stall_cycles = rst ? '0 : stall_cnt;
    assign bus.mc_ops       = rst ? '0 : ops_cnt;
`endif

endmodule
